// File: rtl/signal_ramp_scaler_if.sv
// Sample stream bundle (data + valid) between generator, scaler and DAC stage.
// Zero latency, no backpressure: the consumer must take every valid beat.
interface signal_ramp_scaler_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/signal_ramp_scaler.sv
// Scales samples by amplitude x ramp envelope, adds DC offset, saturates to DAC range.
// Latency 3 cycles (valid delayed alongside data); no backpressure, every cycle is accepted.
module signal_ramp_scaler #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int DAC_WIDTH        = 14
) (
    input  logic                        clk,
    input  logic                        aresetn,
    signal_ramp_scaler_if.slave         s_axis,
    signal_ramp_scaler_if.master        m_axis,
    input  logic                        enable,
    input  logic [15:0]                 amplitude,
    input  logic [15:0]                 ramp_step,
    input  logic signed [DAC_WIDTH-1:0] offset,
    output logic [1:0]                  ramp_state,
    output logic [16:0]                 env
);
    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int PW = W + 1;
    localparam int SW = PW + 1;
    localparam int XW = W + 17;
    localparam logic [16:0] ENV_MAX = 17'd65536;
    localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (DAC_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] env_q, env_d;
    logic [17:0] up_sum;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    // The envelope direction follows enable directly, so reversals continue from the current level.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        up_sum  = {1'b0, env_q} + {2'b00, ramp_step};
        if (enable) begin
            if (ramp_step == 16'd0 || up_sum >= 18'd65536) env_d = ENV_MAX;
            else                                           env_d = up_sum[16:0];
        end else begin
            if (ramp_step == 16'd0 || env_q <= {1'b0, ramp_step}) env_d = '0;
            else                                                  env_d = env_q - {1'b0, ramp_step};
        end
        case (state_q)
            IDLE:      if (enable) state_d = RAMP_UP;
            RAMP_UP:   if (!enable) state_d = RAMP_DOWN;
                       else if (env_q == ENV_MAX) state_d = HOLD;
            HOLD:      if (!enable) state_d = RAMP_DOWN;
            RAMP_DOWN: if (enable) state_d = RAMP_UP;
                       else if (env_q == '0) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign ramp_state = state_q;
    assign env        = env_q;

    logic [15:0]          g_d, g_q;
    logic [W-1:0]         sample_q;
    logic                 v1_q, v2_q, v3_q;
    logic signed [XW-1:0] sample_x, g_x;
    logic [PW-1:0]        p_d, p_q;
    logic signed [SW-1:0] sum;
    logic [DAC_WIDTH-1:0] y_d;
    logic [W-1:0]         out_q;

    assign g_d      = 16'((33'(amplitude) * 33'(env_q)) >> 16);
    assign sample_x = XW'($signed(sample_q));
    assign g_x      = XW'({1'b0, g_q});
    // Arithmetic shift of the two's-complement product floors toward -inf.
    assign p_d      = PW'((sample_x * g_x) >>> 16);
    assign sum      = $signed({p_q[PW-1], p_q}) + SW'(offset);

    always_comb begin
        y_d = sum[DAC_WIDTH-1:0];
        if (sum > SAT_HI)      y_d = SAT_HI[DAC_WIDTH-1:0];
        else if (sum < SAT_LO) y_d = SAT_LO[DAC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            g_q      <= '0;
            sample_q <= '0;
            v1_q     <= 1'b0;
            p_q      <= '0;
            v2_q     <= 1'b0;
            out_q    <= '0;
            v3_q     <= 1'b0;
        end else begin
            g_q      <= g_d;
            sample_q <= s_axis.tdata;
            v1_q     <= s_axis.tvalid;
            p_q      <= p_d;
            v2_q     <= v1_q;
            out_q    <= {{(W - DAC_WIDTH){y_d[DAC_WIDTH-1]}}, y_d};
            v3_q     <= v2_q;
        end
    end

    assign m_axis.tdata  = out_q;
    assign m_axis.tvalid = v3_q;
endmodule

// File: tb/tb_signal_ramp_scaler.sv
// Bench for signal_ramp_scaler: arithmetic reference model checked every cycle plus directed literals.
module tb_signal_ramp_scaler;
    logic               clk = 1'b0;
    logic               aresetn;
    logic               enable;
    logic [15:0]        amplitude;
    logic [15:0]        ramp_step;
    logic signed [13:0] offset;
    logic [1:0]         ramp_state;
    logic [16:0]        env;

    signal_ramp_scaler_if #(.WIDTH(16)) s_axis ();
    signal_ramp_scaler_if #(.WIDTH(16)) m_axis ();

    signal_ramp_scaler #(.AXIS_TDATA_WIDTH(16), .DAC_WIDTH(14)) dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .enable     (enable),
        .amplitude  (amplitude),
        .ramp_step  (ramp_step),
        .offset     (offset),
        .ramp_state (ramp_state),
        .env        (env)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: envelope as clamped arithmetic, each sample's scaled value
    // held for two cycles, then offset (current value) added and clamped.
    longint menv, nenv, g, p, y, pd1, pd2, eo;
    int     mst;
    bit     vd1, vd2, ev, mvalid = 1'b0;

    always @(posedge clk) begin
        if (!aresetn) begin
            menv = 0; mst = 0; pd1 = 0; pd2 = 0; vd1 = 0; vd2 = 0; eo = 0; ev = 0;
            mvalid = 1'b1;
        end else begin
            g  = (longint'(amplitude) * menv) >>> 16;
            p  = (longint'($signed(s_axis.tdata)) * g) >>> 16;
            y  = pd2 + longint'(offset);
            eo = (y > 8191) ? 8191 : ((y < -8192) ? -8192 : y);
            ev = vd2;
            pd2 = pd1; pd1 = p; vd2 = vd1; vd1 = s_axis.tvalid;
            if (enable) nenv = (ramp_step == 0 || menv + ramp_step > 65536) ? 65536 : menv + ramp_step;
            else        nenv = (ramp_step == 0 || menv < ramp_step) ? 0 : menv - ramp_step;
            case (mst)
                0: if (enable) mst = 1;
                1: if (!enable) mst = 3; else if (menv == 65536) mst = 2;
                2: if (!enable) mst = 3;
                default: if (enable) mst = 1; else if (menv == 0) mst = 0;
            endcase
            menv = nenv;
        end
    end

    logic [15:0] exp16;
    always @(negedge clk) begin
        if (mvalid) begin
            exp16 = eo[15:0];
            check("cyc_tdata", int'(m_axis.tdata), int'(exp16));
            check("cyc_tvalid", int'(m_axis.tvalid), int'(ev));
            check("cyc_state", int'(ramp_state), mst);
            check("cyc_env", int'(env), int'(menv));
        end
    end

    initial begin
        aresetn = 1'b0; enable = 1'b0; amplitude = '0; ramp_step = '0; offset = '0;
        s_axis.tdata = '0; s_axis.tvalid = 1'b0;
        tick(3);
        check("rst_env", int'(env), 0);
        check("rst_state", int'(ramp_state), 0);
        check("rst_tdata", int'(m_axis.tdata), 0);
        check("rst_tvalid", int'(m_axis.tvalid), 0);

        aresetn = 1'b1; s_axis.tdata = 16'd8191; amplitude = 16'hFFFF;
        tick(4);
        s_axis.tvalid = 1'b1;
        tick(2);
        check("vld_lat2", int'(m_axis.tvalid), 0);
        tick(1);
        check("vld_lat3", int'(m_axis.tvalid), 1);

        // Instant jump with ramp_step = 0
        enable = 1'b1;
        tick(1);
        check("jump_env", int'(env), 65536);
        check("jump_state", int'(ramp_state), 1);
        tick(1);
        check("jump_hold", int'(ramp_state), 2);
        tick(1);
        check("jump_out_e3", int'(m_axis.tdata), 0);
        tick(1);
        check("jump_out_e4", int'(m_axis.tdata), 8190);

        enable = 1'b0;
        tick(2);
        check("back_idle", int'(ramp_state), 0);

        ramp_step = 16'd16384; enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("up_env", int'(env), 16384 * i);
            check("up_state", int'(ramp_state), 1);
        end
        tick(1);
        check("up_hold", int'(ramp_state), 2);
        tick(3);
        check("up_out", int'(m_axis.tdata), 8190);
        enable = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            tick(1);
            check("dn_env", int'(env), 16384 * i);
            check("dn_state", int'(ramp_state), 3);
        end
        tick(1);
        check("dn_idle", int'(ramp_state), 0);

        // Saturation at full gain
        ramp_step = 16'd0; enable = 1'b1;
        tick(2);
        offset = 14'sd8000;
        tick(4);
        check("sat_hi", int'(m_axis.tdata), 8191);
        offset = 14'sd0; s_axis.tdata = 16'hE001;
        tick(4);
        check("neg_floor", int'(m_axis.tdata), 'hE001);
        offset = 14'sh2000;
        tick(4);
        check("sat_lo", int'(m_axis.tdata), 'hE000);

        // Reversal mid-ramp
        offset = 14'sd0; s_axis.tdata = 16'd8191; enable = 1'b0;
        tick(2);
        ramp_step = 16'd1000; enable = 1'b1;
        tick(5);
        check("rev_top", int'(env), 5000);
        enable = 1'b0;
        for (int i = 4; i >= 2; i--) begin
            tick(1);
            check("rev_dn", int'(env), 1000 * i);
            check("rev_dn_st", int'(ramp_state), 3);
        end
        enable = 1'b1;
        tick(1);
        check("rev_up", int'(env), 3000);
        check("rev_up_st", int'(ramp_state), 1);

        // Idle output equals offset
        enable = 1'b0; ramp_step = 16'd0;
        tick(2);
        offset = -14'sd100;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            s_axis.tdata = 16'($urandom_range(16382)) - 16'd8191;
            tick(1);
            check("idle_offset", int'(m_axis.tdata), 'hFF9C);
        end

        // Reset in the middle of a ramp
        offset = 14'sd0; ramp_step = 16'd1000; enable = 1'b1;
        tick(30);
        check("mid_env", int'(env), 30000);
        aresetn = 1'b0;
        tick(1);
        check("mrst_env", int'(env), 0);
        check("mrst_state", int'(ramp_state), 0);
        check("mrst_tdata", int'(m_axis.tdata), 0);
        check("mrst_tvalid", int'(m_axis.tvalid), 0);
        aresetn = 1'b1;
        tick(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
